// File: rtl/kgprisc_alu_pkg.sv
// rtl/kgprisc_alu_pkg.sv - shared ALU flag positions, response record and driver FSM states
package kgprisc_alu_pkg;

    localparam int FLAG_CARRY = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_ZERO  = 0;

    localparam int ALU_DATA_W = 32;
    localparam int ALU_TAG_W  = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } drv_state_e;

    typedef struct packed {
        logic [ALU_DATA_W-1:0] out;
        logic [2:0]            flag;
        logic [ALU_TAG_W-1:0]  tag;
    } alu_rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// rtl/alu_rsp_fifo.sv - synchronous result FIFO with occupancy count, power-of-2 depth
module alu_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = wr_en && (count_q != (AW+1)'(DEPTH));
    assign do_pop  = rd_en && (count_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; rd_valid masks stale content.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != '0);
    assign count    = count_q;

endmodule

// File: rtl/alu_req_driver.sv
// rtl/alu_req_driver.sv - registers ALU operands, captures out/flag into a tagged result FIFO; optional stats via ALU_REQ_DRIVER_STATS_EN
module alu_req_driver
    import kgprisc_alu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int CTRL_W    = 4,
    parameter int SHAMT_W   = 5,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DATA_W-1:0]  req_in1,
    input  logic [DATA_W-1:0]  req_in2,
    input  logic [SHAMT_W-1:0] req_shamt,
    input  logic [CTRL_W-1:0]  req_control,
    input  logic [TAG_W-1:0]   req_tag,
    output logic [DATA_W-1:0]  alu_in1,
    output logic [DATA_W-1:0]  alu_in2,
    output logic [SHAMT_W-1:0] alu_shamt,
    output logic [CTRL_W-1:0]  alu_control,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic [2:0]         alu_flag,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_out,
    output logic [2:0]         rsp_flag,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [2:0]         flag_reg,
    output logic               busy
`ifdef ALU_REQ_DRIVER_STATS_EN
    ,
    output logic [31:0]        op_count,
    output logic [31:0]        carry_count
`endif
);

    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
    localparam int RSP_W = DATA_W + 3 + TAG_W;

    drv_state_e       state_q, state_d;
    logic [TAG_W-1:0] tag_q;
    logic [2:0]       flag_q;
    logic             accept;
    logic             push;
    logic [CNT_W-1:0] rsp_count;
    logic [RSP_W-1:0] rsp_data;

    // Ready comes from the registered count, so a pop frees a slot one edge later.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        push      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = !rst && (rsp_count < CNT_W'(RSP_DEPTH));
                if (req_valid && req_ready) state_d = DRIVE;
            end
            DRIVE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_shamt   <= '0;
            alu_control <= '0;
            tag_q       <= '0;
            flag_q      <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_in1     <= req_in1;
                alu_in2     <= req_in2;
                alu_shamt   <= req_shamt;
                alu_control <= req_control;
                tag_q       <= req_tag;
            end
            if (push) flag_q <= alu_flag;
        end
    end

    alu_rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (push),
        .wr_data  ({alu_out, alu_flag, tag_q}),
        .rd_en    (rsp_ready),
        .rd_data  (rsp_data),
        .rd_valid (rsp_valid),
        .count    (rsp_count)
    );

    assign {rsp_out, rsp_flag, rsp_tag} = rsp_data;
    assign flag_reg = flag_q;
    assign busy     = (state_q == DRIVE) || (rsp_count != '0);

`ifdef ALU_REQ_DRIVER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count    <= '0;
            carry_count <= '0;
        end else if (push) begin
            if (op_count != '1) op_count <= op_count + 32'd1;
            if (alu_flag[FLAG_CARRY] && (carry_count != '1)) carry_count <= carry_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_req_driver.sv
// tb/tb_alu_req_driver.sv - table, directed and randomized checks of alu_req_driver against a queue model
module tb_alu_req_driver;
    import kgprisc_alu_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_in1, req_in2;
    logic [4:0]  req_shamt;
    logic [3:0]  req_control, req_tag;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_control;
    logic [2:0]  alu_flag;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_out;
    logic [2:0]  rsp_flag, flag_reg;
    logic [3:0]  rsp_tag;
    logic        busy;

    always #5 clk = ~clk;

    alu_req_driver #(.DATA_W(32), .CTRL_W(4), .SHAMT_W(5), .TAG_W(4), .RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_in1(req_in1), .req_in2(req_in2), .req_shamt(req_shamt),
        .req_control(req_control), .req_tag(req_tag),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_shamt(alu_shamt), .alu_control(alu_control),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_out(rsp_out), .rsp_flag(rsp_flag), .rsp_tag(rsp_tag),
        .flag_reg(flag_reg), .busy(busy)
    );

    // ALU stub: adder with carry out of bit 32, zero/negative from the sum
    logic [32:0] stub_sum;
    assign stub_sum = {1'b0, alu_in1} + {1'b0, alu_in2};
    assign alu_out  = stub_sum[31:0];
    assign alu_flag = {stub_sum[32], stub_sum[31], stub_sum[31:0] == 32'd0};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic alu_rsp_t model_rsp(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        alu_rsp_t    r;
        logic [63:0] s;
        s = {32'd0, a} + {32'd0, b};
        r.out              = s[31:0];
        r.flag[FLAG_CARRY] = (s > 64'h0000_0000_FFFF_FFFF);
        r.flag[FLAG_NEG]   = (r.out >= 32'h8000_0000);
        r.flag[FLAG_ZERO]  = (r.out == 32'd0);
        r.tag              = t;
        return r;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctrl;
        logic [3:0]  tag;
        logic [31:0] eout;
        logic [2:0]  eflag;
    } vec_t;
    vec_t vecs[6];

    // Scoreboard: in-flight op, expected FIFO contents, expected flag register
    bit         mon_en = 1'b0;
    bit         m_inflight;
    bit         m_ready;
    bit         m_acc;
    alu_rsp_t   m_pend;
    alu_rsp_t   mq[$];
    logic [2:0] m_flag;
    logic [3:0] popped[$];

    always @(negedge clk) begin
        #2;
        if (mon_en) begin
            m_ready = !m_inflight && (mq.size() < DEPTH);
            chk("mon_req_ready", req_ready, m_ready);
            chk("mon_rsp_valid", rsp_valid, mq.size() > 0);
            chk("mon_busy", busy, m_inflight || (mq.size() > 0));
            chk("mon_flag_reg", flag_reg, m_flag);
            if (mq.size() > 0) begin
                chk("mon_rsp_out", rsp_out, mq[0].out);
                chk("mon_rsp_flag", rsp_flag, mq[0].flag);
                chk("mon_rsp_tag", rsp_tag, mq[0].tag);
            end
            m_acc = req_valid && m_ready;
            if ((mq.size() > 0) && rsp_ready) begin
                popped.push_back(mq[0].tag);
                void'(mq.pop_front());
            end
            if (m_inflight) begin
                mq.push_back(m_pend);
                m_flag = m_pend.flag;
            end
            m_inflight = m_acc;
            if (m_acc) m_pend = model_rsp(req_in1, req_in2, req_tag);
        end
    end

    task automatic present(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c, input logic [3:0] t);
        @(negedge clk);
        req_valid   = 1'b1;
        req_in1     = a;
        req_in2     = b;
        req_control = c;
        req_shamt   = 5'($urandom);
        req_tag     = t;
    endtask

    task automatic wait_accept(input int bound);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            #1;
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
        else begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
        present(a, b, 4'($urandom), t);
        wait_accept(20);
    endtask

    task automatic wait_idle(input int bound);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
        #3;
        if (mon_en) chk("model_drained", mq.size(), 0);
    endtask

    task automatic single(input vec_t v);
        present(v.a, v.b, v.ctrl, v.tag);
        #1 chk("single_ready", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("lat_not_yet_valid", rsp_valid, 0);
        chk("drive_busy", busy, 1);
        chk("drive_not_ready", req_ready, 0);
        chk("alu_in1", alu_in1, v.a);
        chk("alu_in2", alu_in2, v.b);
        chk("alu_control", alu_control, v.ctrl);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("lat_valid", rsp_valid, 1);
        chk("rsp_out", rsp_out, v.eout);
        chk("rsp_flag", rsp_flag, v.eflag);
        chk("rsp_tag", rsp_tag, v.tag);
        chk("flag_reg", flag_reg, v.eflag);
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        chk("popped_empty", rsp_valid, 0);
        chk("idle_not_busy", busy, 0);
        chk("alu_in1_hold", alu_in1, v.a);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vecs[0] = '{32'd105,        32'd1,          4'b0001, 4'd3,  32'd211,        3'b000};
        vecs[0].b = 32'd106;
        vecs[1] = '{32'hFFFF_FFFF,  32'd1,          4'b0010, 4'd5,  32'd0,          3'b101};
        vecs[2] = '{32'h8000_0000,  32'd0,          4'b0011, 4'd7,  32'h8000_0000,  3'b010};
        vecs[3] = '{32'h8000_0000,  32'h8000_0000,  4'b0100, 4'd9,  32'd0,          3'b101};
        vecs[4] = '{32'h7FFF_FFFF,  32'd1,          4'b0101, 4'd2,  32'h8000_0000,  3'b010};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'b1111, 4'hF,  32'hFFFF_FFFE,  3'b110};

        rst = 1'b1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        req_in1 = '0; req_in2 = '0; req_shamt = '0; req_control = '0; req_tag = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_in1", alu_in1, 0);
        chk("rst_alu_control", alu_control, 0);
        chk("rst_flag_reg", flag_reg, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_busy", busy, 0);

        for (int i = 0; i < 6; i++) single(vecs[i]);

        m_inflight = 1'b0;
        mq.delete();
        m_flag = vecs[5].eflag;
        mon_en = 1'b1;

        // Backpressure: two ops fill the FIFO, the third stalls until a pop
        popped.delete();
        issue(32'd10, 32'd20, 4'd1);
        issue(32'd30, 32'd40, 4'd2);
        present(32'd50, 32'd60, 4'd0, 4'd3);
        repeat (4) begin
            #1 chk("bp_stall_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        wait_accept(10);
        wait_idle(20);
        chk("bp_order", (popped.size() == 3) ? {popped[0], popped[1], popped[2]} : 12'hFFF, 12'h123);

        // Full FIFO drained at one per cycle while new ops keep arriving
        rsp_ready = 1'b0;
        issue($urandom, $urandom, 4'd4);
        issue($urandom, $urandom, 4'd5);
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int k = 6; k < 12; k++) issue(pick(), pick(), 4'(k));
        wait_idle(20);

        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            req_valid   = ($urandom_range(0, 1) == 1);
            rsp_ready   = ($urandom_range(0, 3) != 0);
            req_in1     = pick();
            req_in2     = pick();
            req_shamt   = 5'($urandom);
            req_control = 4'($urandom);
            req_tag     = 4'($urandom);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle(20);
        mon_en = 1'b0;
        rsp_ready = 1'b0;

        // Reset while an op is in DRIVE discards it and clears flag_reg
        single(vecs[1]);
        present(32'd7, 32'd8, 4'd1, 4'hA);
        #1 chk("rd_ready", req_ready, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rd_busy", busy, 0);
        chk("rd_rsp_valid", rsp_valid, 0);
        chk("rd_flag_reg", flag_reg, 0);
        chk("rd_req_ready", req_ready, 0);
        chk("rd_alu_in1", alu_in1, 0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rd_after_valid", rsp_valid, 0);
            chk("rd_after_busy", busy, 0);
        end
        single(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
